// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths, default threshold offsets and parameter sanity checks for sync_fifo_flags.
// Contents:
//   AF_OFFSET  - default distance of almost_full threshold below DEPTH
//   AE_DEFAULT - default almost_empty threshold
//   ptr_width  - pointer/count width for a given depth (index bits + wrap bit)
//   cfg_ok     - true when DEPTH, ADDR_WIDTH and the thresholds form a legal configuration
package sync_fifo_pkg;

    localparam int AF_OFFSET  = 2;
    localparam int AE_DEFAULT = 2;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit cfg_ok(input int depth, input int addr_width, input int af, input int ae);
        return depth >= 4 && (depth & (depth - 1)) == 0 && ptr_width(depth) == addr_width + 1
            && ae < af && af <= depth;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read, contents never reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   w_addr - write address
//   w_data - write data
//   r_addr - read address
//   r_data - combinational read data at r_addr
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[w_addr] <= w_data;

    assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, almost-full/empty thresholds and sticky error flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through output (zero read latency);
// otherwise data_out is registered with one cycle of read latency.
// Ports:
//   clk, rst       - clock (rising edge), synchronous active-low reset
//   w_en, data_in  - write request and data
//   r_en           - read request (pop/acknowledge in FWFT mode)
//   data_out       - read data; rd_valid marks a fresh word
//   full, empty    - occupancy extremes, derived from pointers
//   almost_full    - count >= AF_LEVEL
//   almost_empty   - count <= AE_LEVEL
//   count          - occupancy 0..DEPTH
//   overflow       - sticky: write refused because full
//   underflow      - sticky: read attempted while empty
//   err_clr        - synchronous clear of overflow/underflow
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = DEPTH - AF_OFFSET,
    parameter int AE_LEVEL   = AE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    if (!cfg_ok(DEPTH, ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
        $error("sync_fifo_flags: illegal DEPTH/ADDR_WIDTH/AF_LEVEL/AE_LEVEL combination");
    end

    localparam logic [ADDR_WIDTH:0] ONE  = 1;
    localparam logic [ADDR_WIDTH:0] AF_W = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_W = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0]   w_ptr, r_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  rd_acc, wr_acc;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty        = w_ptr == r_ptr;
    assign full         = (w_ptr[ADDR_WIDTH] != r_ptr[ADDR_WIDTH]) && (w_ptr[ADDR_WIDTH-1:0] == r_ptr[ADDR_WIDTH-1:0]);
    assign almost_full  = count >= AF_W;
    assign almost_empty = count <= AE_W;
    assign rd_acc       = r_en & ~empty;
    // A write into a full FIFO is safe only when a read frees the slot in the same cycle.
    assign wr_acc       = w_en & (~full | rd_acc);

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .w_addr(w_ptr[ADDR_WIDTH-1:0]),
        .w_data(data_in),
        .r_addr(r_ptr[ADDR_WIDTH-1:0]),
        .r_data(r_data)
    );

    always_ff @(posedge clk)
        if (!rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) w_ptr <= w_ptr + ONE;
            if (rd_acc) r_ptr <= r_ptr + ONE;
            count     <= count + (wr_acc ? ONE : '0) - (rd_acc ? ONE : '0);
            // A new error event outranks a simultaneous clear.
            overflow  <= (w_en & full & ~rd_acc) | (overflow & ~err_clr);
            underflow <= (r_en & empty) | (underflow & ~err_clr);
        end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; zero while empty so stale storage never shows.
    assign data_out = empty ? '0 : r_data;
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk)
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (rd_acc) data_out <= r_data;
            rd_valid <= rd_acc;
        end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags (default DATA_WIDTH=8, DEPTH=16).
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en, err_clr;
    logic [7:0] data_in, data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         n_checks = 0;
    int         n_fail = 0;

    sync_fifo_flags dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = '0;
        tick; tick;
        rst = 1'b1;
        tick;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            tick;
            n_checks++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            n_checks++; if (full !== (i == 16)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, i == 16); end
            n_checks++; if (almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_almost_full i=%0d got=%b exp=%b", i, almost_full, i >= 14); end
            n_checks++; if (almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_almost_empty i=%0d got=%b exp=%b", i, almost_empty, i <= 2); end
            n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
        end
        data_in = 8'h77;
        tick;
        w_en = 1'b0;
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL overflow_count got=%0d exp=16", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag got=%b exp=1", overflow); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL overflow_full got=%b exp=1", full); end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 16; i++) begin
            r_en = 1'b1;
            tick;
            n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_rd_valid i=%0d got=%b exp=1", i, rd_valid); end
            n_checks++; if (data_out !== 8'(i)) begin n_fail++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, 8'(i)); end
            n_checks++; if (count !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 16 - i); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", empty); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_no_underflow got=%b exp=0", underflow); end
        tick;
        r_en = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_flag got=%b exp=1", underflow); end
        n_checks++; if (data_out !== 8'h10) begin n_fail++; $display("FAIL underflow_hold got=%h exp=10", data_out); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_rd_valid got=%b exp=0", rd_valid); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL underflow_count got=%0d exp=0", count); end
        err_clr = 1'b1; r_en = 1'b1;
        tick;
        r_en = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set underflow got=%b exp=1", underflow); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr overflow got=%b exp=0", overflow); end
        tick;
        err_clr = 1'b0;
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL clr underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_simultaneous;
        for (int i = 1; i <= 16; i++) begin
            w_en = 1'b1; data_in = 8'(8'h20 + i);
            tick;
        end
        r_en = 1'b1; data_in = 8'hAA;
        tick;
        w_en = 1'b0; r_en = 1'b0;
        n_checks++; if (data_out !== 8'h21) begin n_fail++; $display("FAIL full_rw_data got=%h exp=21", data_out); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL full_rw_count got=%0d exp=16", count); end
        n_checks++; if ({full, overflow} !== 2'b10) begin n_fail++; $display("FAIL full_rw_flags full/ovf got=%b exp=10", {full, overflow}); end
        for (int i = 2; i <= 17; i++) begin
            r_en = 1'b1;
            tick;
            n_checks++; if (data_out !== ((i == 17) ? 8'hAA : 8'(8'h20 + i))) begin n_fail++; $display("FAIL full_rw_drain i=%0d got=%h", i, data_out); end
        end
        w_en = 1'b1; data_in = 8'h33;
        tick;
        w_en = 1'b0; r_en = 1'b0;
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL empty_rw_count got=%0d exp=1", count); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL empty_rw_underflow got=%b exp=1", underflow); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rw_rd_valid got=%b exp=0", rd_valid); end
        r_en = 1'b1; err_clr = 1'b1;
        tick;
        r_en = 1'b0; err_clr = 1'b0;
        n_checks++; if (data_out !== 8'h33) begin n_fail++; $display("FAIL empty_rw_data got=%h exp=33", data_out); end
        n_checks++; if ({empty, underflow} !== 2'b10) begin n_fail++; $display("FAIL empty_rw_end empty/udf got=%b exp=10", {empty, underflow}); end
    endtask

    task automatic test_wrap;
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < 5; k++) begin
                if (b % 2 == 0) begin
                    w_en = 1'b1; data_in = 8'(b * 5 + k);
                    q.push_back(data_in);
                    tick;
                end else begin
                    r_en = 1'b1;
                    exp = q.pop_front();
                    tick;
                    n_checks++; if (data_out !== exp) begin n_fail++; $display("FAIL wrap_data b=%0d k=%0d got=%h exp=%h", b, k, data_out, exp); end
                end
                n_checks++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL wrap_count b=%0d k=%0d got=%0d exp=%0d", b, k, count, q.size()); end
                n_checks++; if (empty !== (q.size() == 0)) begin n_fail++; $display("FAIL wrap_empty b=%0d k=%0d got=%b", b, k, empty); end
            end
            w_en = 1'b0; r_en = 1'b0;
        end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL wrap_errs got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_midreset;
        r_en = 1'b1;
        tick;
        r_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            w_en = 1'b1; data_in = 8'(8'h40 + i);
            tick;
        end
        n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL midreset_pre_count got=%0d exp=7", count); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_udf got=%b exp=1", underflow); end
        rst = 1'b0; r_en = 1'b1;
        tick;
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL midreset_count got=%0d exp=0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midreset_empty got=%b exp=1", empty); end
        n_checks++; if ({overflow, underflow, rd_valid} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags got=%b exp=000", {overflow, underflow, rd_valid}); end
    endtask

    task automatic test_fwft;
        w_en = 1'b1; data_in = 8'h5A;
        tick;
        w_en = 1'b0;
        n_checks++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL fwft_data got=%h exp=5a", data_out); end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_rd_valid got=%b exp=1", rd_valid); end
        r_en = 1'b1;
        tick;
        r_en = 1'b0;
        n_checks++; if ({empty, rd_valid} !== 2'b10) begin n_fail++; $display("FAIL fwft_pop empty/valid got=%b exp=10", {empty, rd_valid}); end
    endtask

    initial begin
        test_reset;
        test_fill;
`ifdef SYNC_FIFO_FWFT_EN
        rst = 1'b0;
        tick;
        rst = 1'b1;
`else
        test_drain;
        test_simultaneous;
        test_wrap;
`endif
        test_midreset;
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
